mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single unified `mem_system` cache/memory between the fetch stage (instruction requester, I) and the memory stage (data requester, D). It latches the winning request, holds the `mem_system` Rd/Wr, Addr and DataIn stable until `Done`, and routes `DataOut`/`Done` back to the winner. It sits between the pipeline stages and `mem_system`, in place of direct per-stage memory instances.

## Interface
- `STARVE_MAX`, default 4: consecutive D grants allowed while I is pending before I is forced next.
- `WD_LIMIT`, default 255: watchdog cycle limit (only with `MEM_ARB_WATCHDOG_EN`).

Ports:
- `clk` input 1: system clock; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `i_rd` input 1: instruction read request; held high until `i_done`.
- `i_addr` input 16: instruction address.
- `d_rd`, `d_wr` input 1 each: data read or write request; held until `d_done`.
- `d_addr`, `d_wdata` input 16: data address and write data.
- `i_data`, `d_data` output 16: read data from `mem_system` DataOut; valid while the matching done is high.
- `i_done`, `d_done` output 1: one-cycle completion pulse to the granted requester.
- `i_stall`, `d_stall` output 1: requester pending and not completing this cycle.
- `err` output 1: sticky protocol error (`d_rd & d_wr`, or watchdog expiry).
- `m_addr`, `m_wdata` output 16: to `mem_system` Addr / DataIn (registered).
- `m_rd`, `m_wr` output 1: to `mem_system` Rd / Wr (registered).
- `m_data` input 16, `m_done` input 1, `m_stall` input 1: from `mem_system` DataOut / Done / Stall.

## Operation
- FSM states: IDLE, GNT_I, GNT_D, TURN.
- IDLE: when both requesters are pending, D wins, unless the starve counter has reached `STARVE_MAX`, in which case I wins. A single pending request is granted. No requests leaves the FSM in IDLE.
- On grant, register the op, address and write data into `m_*`. Move to GNT_I or GNT_D.
- GNT_x: hold `m_rd`/`m_wr`/`m_addr`/`m_wdata` constant and ignore new input values. On `m_done`, pulse `x_done` and move to TURN. Nothing is issued on the `m_done` cycle.
- TURN: `m_rd = m_wr = 0` for one cycle (mem_system request-drop cycle), then IDLE.
- Starve counter (3 bits, saturating at `STARVE_MAX`):
  - increments on each D grant while `i_rd` is high;
  - clears on an I grant, or when a D grant occurs while `i_rd` is low.
- `d_rd & d_wr` both high in IDLE: request not granted, `err` set, D stays stalled. I is still serviced.
- `i_data = d_data = m_data` (combinational pass-through).
- `i_done = m_done & GNT_I`; `d_done = m_done & GNT_D`.
- `i_stall = i_rd & ~i_done`; `d_stall = (d_rd | d_wr) & ~d_done`.
- `m_stall` is informational only. It is not used for control; `m_done` alone ends a transaction.

## Timing
- Reset: FSM = IDLE, all `m_*` = 0, starve counter = 0, watchdog = 0, `err` = 0, done pulses = 0.
- Request high in IDLE at cycle N: `m_rd`/`m_wr` high from cycle N+1.
- `m_done` at cycle M: `x_done` and `x_data` valid at cycle M; TURN at M+1; next grant decided at M+2, issued at M+3.
- Back-to-back throughput: one access per (mem latency + 2) cycles.
- Cache hit (`m_done` at N+1): request-to-done latency is 2 cycles.
- New request arriving during GNT/TURN: waits, with its stall held high.
- Simultaneous I and D arrival in IDLE: D first, per the starve rule.
- `rst` mid-transaction: outstanding request dropped, no done pulse issued, outputs return to reset values asynchronously.

## Configuration
- `MEM_ARB_WATCHDOG_EN` defined:
  - an 8-bit counter runs in GNT_x and clears on grant;
  - reaching `WD_LIMIT` without `m_done` sets `err`, forces the FSM to TURN and drops the request with no done pulse;
  - the requester keeps stalling and is re-arbitrated.
- Undefined: no counter. GNT_x waits indefinitely; `err` reflects only the `d_rd & d_wr` case.

## Test plan
- Lone I read, addr 0x0010, `m_done` after 1 cycle with `m_data` 0xBEEF → `m_rd` high at N+1, `i_done` at N+2 with `i_data` 0xBEEF, `d_done` stays 0.
- I and D both pending, D write 0x0020 ← 0x1234 → D granted first (`m_wr` = 1, `m_wdata` 0x1234), TURN cycle, then I granted; I sees `i_stall` high throughout.
- D held pending continuously with I pending → after 4 D grants, the 5th grant goes to I; starve counter then reads 0.
- `d_rd = d_wr = 1` → `err` = 1, no D grant, a concurrent I request completes normally.
- `rst` pulsed in GNT_D before `m_done` → immediate `m_wr` = 0, FSM IDLE, no `d_done`.
- With `MEM_ARB_WATCHDOG_EN`, hold `m_done` = 0 for 255 cycles → `err` = 1, FSM passes through TURN, request re-issued.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch I / memory-stage D) arbiter in front of the unified mem_system.
// Optional watchdog on stuck transactions is enabled by defining MEM_ARB_WATCHDOG_EN.
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int WD_LIMIT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rd,
  input  logic [15:0] i_addr,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] i_data,
  output logic [15:0] d_data,
  output logic        i_done,
  output logic        d_done,
  output logic        i_stall,
  output logic        d_stall,
  output logic        err,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [15:0] m_data,
  input  logic        m_done,
  input  logic        m_stall
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, TURN} state_e;

  state_e      state_q, state_d;
  logic        m_rd_q, m_rd_d;
  logic        m_wr_q, m_wr_d;
  logic [15:0] m_addr_q, m_addr_d;
  logic [15:0] m_wdata_q, m_wdata_d;
  logic [2:0]  starve_q, starve_d;
  logic        err_q, err_d;

  logic d_req_ok;
  logic d_req_bad;
  logic starve_full;

  // mem_system Stall is informational; m_done alone ends a transaction.
  logic unused_m_stall;
  assign unused_m_stall = m_stall;

`ifdef MEM_ARB_WATCHDOG_EN
  logic [7:0] wd_q, wd_d;
`else
  localparam int unused_wd_limit = WD_LIMIT;
`endif

  assign d_req_ok    = d_rd ^ d_wr;
  assign d_req_bad   = d_rd & d_wr;
  assign starve_full = (starve_q >= 3'(STARVE_MAX));

  always_comb begin
    state_d   = state_q;
    m_rd_d    = m_rd_q;
    m_wr_d    = m_wr_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    starve_d  = starve_q;
    err_d     = err_q;
`ifdef MEM_ARB_WATCHDOG_EN
    wd_d      = wd_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_req_bad) err_d = 1'b1;
        // D has priority unless I has been passed over STARVE_MAX times in a row.
        if (i_rd && (!d_req_ok || starve_full)) begin
          state_d   = GNT_I;
          m_rd_d    = 1'b1;
          m_wr_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = 16'h0000;
          starve_d  = 3'd0;
`ifdef MEM_ARB_WATCHDOG_EN
          wd_d      = 8'd0;
`endif
        end else if (d_req_ok) begin
          state_d   = GNT_D;
          m_rd_d    = d_rd;
          m_wr_d    = d_wr;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          if (!i_rd)            starve_d = 3'd0;
          else if (!starve_full) starve_d = starve_q + 3'd1;
`ifdef MEM_ARB_WATCHDOG_EN
          wd_d      = 8'd0;
`endif
        end
      end
      GNT_I, GNT_D: begin
        if (m_done) begin
          state_d = TURN;
          m_rd_d  = 1'b0;
          m_wr_d  = 1'b0;
`ifdef MEM_ARB_WATCHDOG_EN
        end else if (wd_q == 8'(WD_LIMIT - 1)) begin
          // Abandon the access; the requester still stalls and is re-arbitrated.
          state_d = TURN;
          m_rd_d  = 1'b0;
          m_wr_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
`endif
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      m_rd_q    <= 1'b0;
      m_wr_q    <= 1'b0;
      m_addr_q  <= 16'h0000;
      m_wdata_q <= 16'h0000;
      starve_q  <= 3'd0;
      err_q     <= 1'b0;
`ifdef MEM_ARB_WATCHDOG_EN
      wd_q      <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      m_rd_q    <= m_rd_d;
      m_wr_q    <= m_wr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      starve_q  <= starve_d;
      err_q     <= err_d;
`ifdef MEM_ARB_WATCHDOG_EN
      wd_q      <= wd_d;
`endif
    end
  end

  assign m_rd    = m_rd_q;
  assign m_wr    = m_wr_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign err     = err_q;

  assign i_data  = m_data;
  assign d_data  = m_data;
  assign i_done  = m_done & (state_q == GNT_I);
  assign d_done  = m_done & (state_q == GNT_D);
  assign i_stall = i_rd & ~i_done;
  assign d_stall = (d_rd | d_wr) & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grants, D priority, starvation relief, protocol error, async reset.
// The watchdog scenario runs when MEM_ARB_WATCHDOG_EN is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rd, d_rd, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [15:0] i_data, d_data;
  logic        i_done, d_done, i_stall, d_stall, err;
  logic [15:0] m_addr, m_wdata, m_data;
  logic        m_rd, m_wr, m_done, m_stall;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_rd(i_rd), .i_addr(i_addr),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_data(i_data), .d_data(d_data),
    .i_done(i_done), .d_done(d_done),
    .i_stall(i_stall), .d_stall(d_stall), .err(err),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
    .m_data(m_data), .m_done(m_done), .m_stall(m_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    m_data = 16'h0; m_done = 1'b0; m_stall = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_m_rd",    32'(m_rd), 0);
    check("rst_m_wr",    32'(m_wr), 0);
    check("rst_m_addr",  32'(m_addr), 0);
    check("rst_m_wdata", 32'(m_wdata), 0);
    check("rst_err",     32'(err), 0);
    check("rst_starve",  32'(dut.starve_q), 0);
    tick();

    // Lone I read: issued next cycle, done one cycle later.
    i_rd = 1'b1; i_addr = 16'h0010;
    #1; check("i1_stall_req", 32'(i_stall), 1);
    tick();
    check("i1_m_rd",   32'(m_rd), 1);
    check("i1_m_wr",   32'(m_wr), 0);
    check("i1_m_addr", 32'(m_addr), 32'h0010);
    tick();
    m_done = 1'b1; m_data = 16'hBEEF; m_stall = 1'b1;
    #1;
    check("i1_done",  32'(i_done), 1);
    check("i1_data",  32'(i_data), 32'hBEEF);
    check("i1_ddone", 32'(d_done), 0);
    check("i1_stall", 32'(i_stall), 0);
    tick();
    m_done = 1'b0; m_stall = 1'b0; i_rd = 1'b0;
    check("i1_turn_m_rd", 32'(m_rd), 0);
    tick();

    // Simultaneous I read and D write: D first, TURN, then I.
    i_rd = 1'b1; i_addr = 16'h0030;
    d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
    tick();
    check("both_d_m_wr",    32'(m_wr), 1);
    check("both_d_m_rd",    32'(m_rd), 0);
    check("both_d_m_addr",  32'(m_addr), 32'h0020);
    check("both_d_m_wdata", 32'(m_wdata), 32'h1234);
    check("both_i_stall_g", 32'(i_stall), 1);
    m_done = 1'b1;
    #1;
    check("both_d_done",    32'(d_done), 1);
    check("both_i_done0",   32'(i_done), 0);
    check("both_d_stall",   32'(d_stall), 0);
    tick();
    m_done = 1'b0; d_wr = 1'b0;
    check("both_turn_m_wr", 32'(m_wr), 0);
    check("both_turn_m_rd", 32'(m_rd), 0);
    check("both_i_stall_t", 32'(i_stall), 1);
    tick();
    check("both_idle_m_rd", 32'(m_rd), 0);
    check("both_i_stall_i", 32'(i_stall), 1);
    tick();
    check("both_i_m_rd",    32'(m_rd), 1);
    check("both_i_m_addr",  32'(m_addr), 32'h0030);
    m_done = 1'b1; m_data = 16'h5555;
    #1;
    check("both_i_done",    32'(i_done), 1);
    check("both_i_data",    32'(i_data), 32'h5555);
    tick();
    m_done = 1'b0; i_rd = 1'b0;
    tick();
    check("both_starve0",   32'(dut.starve_q), 0);

    // Both held pending: four D grants, then I is forced.
    i_rd = 1'b1; i_addr = 16'h0050;
    d_rd = 1'b1; d_addr = 16'h0040;
    for (int g = 0; g < 5; g++) begin
      tick();
      if (g < 4) begin
        check($sformatf("stv%0d_m_addr", g), 32'(m_addr), 32'h0040);
        check($sformatf("stv%0d_cnt", g), 32'(dut.starve_q), 32'(g + 1));
      end else begin
        check("stv4_m_addr", 32'(m_addr), 32'h0050);
      end
      check($sformatf("stv%0d_m_rd", g), 32'(m_rd), 1);
      m_done = 1'b1; m_data = 16'(16'h0100 + g);
      #1;
      check($sformatf("stv%0d_i_done", g), 32'(i_done), (g == 4) ? 1 : 0);
      check($sformatf("stv%0d_d_done", g), 32'(d_done), (g == 4) ? 0 : 1);
      tick();
      m_done = 1'b0;
      if (g == 4) begin
        i_rd = 1'b0; d_rd = 1'b0;
      end
      tick();
    end
    check("stv_cnt_after_i", 32'(dut.starve_q), 0);

    // d_rd & d_wr: error, D never granted, concurrent I still served.
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0066;
    i_rd = 1'b1; i_addr = 16'h0050;
    tick();
    check("bad_err",    32'(err), 1);
    check("bad_m_rd",   32'(m_rd), 1);
    check("bad_m_wr",   32'(m_wr), 0);
    check("bad_m_addr", 32'(m_addr), 32'h0050);
    check("bad_dstall", 32'(d_stall), 1);
    m_done = 1'b1; m_data = 16'hA5A5;
    #1;
    check("bad_i_done", 32'(i_done), 1);
    check("bad_i_data", 32'(i_data), 32'hA5A5);
    check("bad_d_done", 32'(d_done), 0);
    tick();
    m_done = 1'b0; i_rd = 1'b0;
    tick();
    tick();
    check("bad_no_rd",  32'(m_rd), 0);
    check("bad_no_wr",  32'(m_wr), 0);
    check("bad_dstall2", 32'(d_stall), 1);
    check("bad_err_sticky", 32'(err), 1);
    d_rd = 1'b0; d_wr = 1'b0;
    tick();

    // Asynchronous reset while D write is outstanding.
    d_wr = 1'b1; d_addr = 16'h0060; d_wdata = 16'h7777;
    tick();
    check("ar_m_wr_pre", 32'(m_wr), 1);
    rst = 1'b1; m_done = 1'b1;
    #1;
    check("ar_m_wr",   32'(m_wr), 0);
    check("ar_m_addr", 32'(m_addr), 0);
    check("ar_err",    32'(err), 0);
    check("ar_d_done", 32'(d_done), 0);
    tick();
    rst = 1'b0; m_done = 1'b0; d_wr = 1'b0;
    tick();
    check("ar_idle_wr", 32'(m_wr), 0);
    check("ar_idle_rd", 32'(m_rd), 0);
    d_rd = 1'b1; d_addr = 16'h0070;
    tick();
    check("ar_new_m_rd",   32'(m_rd), 1);
    check("ar_new_m_addr", 32'(m_addr), 32'h0070);
    m_done = 1'b1; m_data = 16'hC0DE;
    #1;
    check("ar_new_d_done", 32'(d_done), 1);
    check("ar_new_d_data", 32'(d_data), 32'hC0DE);
    tick();
    m_done = 1'b0; d_rd = 1'b0;
    tick();

`ifdef MEM_ARB_WATCHDOG_EN
    // Stuck access: 255 cycles without m_done abandons it and re-issues.
    d_rd = 1'b1; d_addr = 16'h0080;
    tick();
    for (int k = 0; k < 254; k++) tick();
    check("wd_m_rd_hold", 32'(m_rd), 1);
    check("wd_err_pre",   32'(err), 0);
    tick();
    check("wd_turn_m_rd", 32'(m_rd), 0);
    check("wd_err",       32'(err), 1);
    check("wd_d_stall",   32'(d_stall), 1);
    tick();
    check("wd_idle_m_rd", 32'(m_rd), 0);
    tick();
    check("wd_reissue",   32'(m_rd), 1);
    check("wd_re_addr",   32'(m_addr), 32'h0080);
    m_done = 1'b1;
    #1;
    check("wd_d_done",    32'(d_done), 1);
    tick();
    m_done = 1'b0; d_rd = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
